ram_loader: RTL and testbench
=============================

# ram_loader

Serial program loader sitting directly upstream of the 8-bit single-port `ram` block. It consumes a byte stream from the UART receiver, parses a framed load command, and writes the payload into RAM through the RAM's `we`/`addr`/`di` port. While a frame is in progress it holds the CPU off the memory bus. On completion it reports success or a checksum/timeout error.

## Interface
Parameters:
- `ADDR_BITS`, default 16: RAM address width. Must match the `ram` instance.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, default 1000000: idle clocks allowed between bytes inside a frame.

Ports:
- `clk`, in, 1: single clock, shared with `ram`.
- `rst`, in, 1: synchronous, active-high reset.
- `rx_data`, in, 8: received byte.
- `rx_valid`, in, 1: one-cycle strobe qualifying `rx_data`. There is no backpressure.
- `ram_we`, out, 1: write enable to `ram`.
- `ram_addr`, out, ADDR_BITS: write address to `ram`.
- `ram_di`, out, 8: write data to `ram`.
- `cpu_hold`, out, 1: high while a frame is active. The top level uses it to stall the CPU and mux the RAM port.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse on a good frame.
- `error`, out, 1: sticky flag for a bad frame.

## Operation
- Frame format: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes, CHK.
- CHK is the XOR of every byte from ADDR_H through the last data byte.
- States and transitions:
  - IDLE goes to ADDR_H on `rx_valid` with `rx_data==SYNC_BYTE`. Any other byte is ignored.
  - ADDR_H → ADDR_L → LEN_H → LEN_L, one transition per `rx_valid`.
  - LEN_L goes to DATA if LEN≠0, or straight to CHK if LEN==0.
  - DATA stays in DATA until LEN bytes have been received, then goes to CHK.
  - CHK goes to IDLE on the next `rx_valid`.
- Each `rx_valid` in DATA produces exactly one RAM write of `rx_data` at the current address. The address then increments.
- Address arithmetic:
  - The start address is the low ADDR_BITS of {ADDR_H,ADDR_L}.
  - The address increments modulo 2^ADDR_BITS, so it wraps from all-ones to 0.
  - The 16-bit byte counter counts down from LEN. The frame length is LEN, not LEN+1.
- On the CHK byte:
  - If it matches the running XOR, pulse `done`.
  - Otherwise set `error`.
  - Data already written is not rolled back.
- `error` is sticky. It clears only on reset or when a new SYNC is accepted in IDLE.
- Timeout:
  - The counter reloads on every `rx_valid` and counts clocks in any non-IDLE state.
  - When it reaches TIMEOUT_CYCLES, return to IDLE, set `error`, and drop `cpu_hold`. No `done` pulse is produced.
- A SYNC byte received mid-frame is treated as ordinary data. It does not resynchronise the parser.
- Reset at any point returns the block to IDLE immediately. Partial RAM contents remain as written.

## Timing
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_di`=0, `cpu_hold`=0, `busy`=0, `done`=0, `error`=0, state=IDLE.
- All outputs are registered.
- Write latency: `rx_valid` on a data byte in cycle N gives `ram_we`=1 in cycle N+1, with `ram_addr`/`ram_di` valid in that same cycle. `ram_we` is high for exactly one cycle per byte.
- `cpu_hold` and `busy` rise the cycle after SYNC is accepted.
- `cpu_hold` and `busy` fall in the same cycle that `done` or `error` asserts. This is the cycle after the CHK byte, or the cycle after the timeout is reached.
- `done` is high for exactly one cycle.
- Back-to-back `rx_valid` on consecutive clocks must be accepted without loss.

## Structure
- Shared header `ram_loader_defs.vh` holds:
  - the state encodings (IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, CHK);
  - the default SYNC_BYTE.
- A single module is sufficient.
- The timeout counter may optionally be split into sub-module `ram_loader_timeout`, with ports `clk`, `rst`, `kick`, `en` and an `expired` pulse.
- The RAM-port mux between CPU and loader belongs in the top level, not in this block.

## Test plan
- Good frame A5 12 34 00 03 AA BB CC, CHK=12^34^00^03^AA^BB^CC → writes AA@1234, BB@1235, CC@1236. One `done` pulse, `error`=0, `cpu_hold` low afterwards.
- Wrap: start address FFFF, LEN=2, data 11 22 → 11@FFFF, 22@0000. `done` asserted.
- Bad checksum on the same frame as scenario 1 with CHK^1 → all three writes still occur, `error`=1 and stays set. The next SYNC clears `error`.
- LEN=0 frame A5 00 10 00 00 then CHK 10 → no `ram_we`, `done` pulses.
- Timeout: stop the stream after 2 of 5 data bytes, with TIMEOUT_CYCLES=100 → exactly 2 writes. `error` rises 100 cycles after the last byte, state returns to IDLE. A fresh frame then loads correctly.
- Noise and reset: bytes 00 FF before SYNC are ignored. Assert `rst` in the middle of the DATA state → all outputs are 0 the next cycle and the following frame is parsed from SYNC.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg
//   Shared definitions for the serial RAM program loader: parser state
//   encodings and the default frame start marker.
package ram_loader_pkg;

  // Parser states. The numeric encoding is also what appears on the
  // loader's dbg_state output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR_H = 3'd1,
    ST_ADDR_L = 3'd2,
    ST_LEN_H  = 3'd3,
    ST_LEN_L  = 3'd4,
    ST_DATA   = 3'd5,
    ST_CHK    = 3'd6
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/ram_loader_timeout.sv
// ram_loader_timeout
//   Inter-byte watchdog for the loader. Counts clocks while enabled and
//   raises a one-cycle 'expired' pulse on the TIMEOUT_CYCLES-th clock with
//   no kick. A kick (or dropping en) restarts the count from zero.
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset
//   kick    in   restart the count (a byte arrived)
//   en      in   count only while a frame is active
//   expired out  combinational pulse; the parent registers its effect
module ram_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  input  logic en,
  output logic expired
);

  // The counter only ever needs to hold TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry fires on the clock where the count is already at LAST and no
  // byte arrives, so the parent sees its effect exactly TIMEOUT_CYCLES
  // clocks after the most recent byte.
  assign expired = en && !kick && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en || kick) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_loader.sv
// ram_loader
//   Serial program loader in front of the 8-bit single-port RAM. Parses
//   frames of the form SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes,
//   CHK (XOR of ADDR_H..last data byte) and writes the payload to RAM.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
//   backpressure, so every strobe is consumed on the clock it is seen,
//   including strobes on consecutive clocks.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_data/rx_valid  byte stream from the UART receiver
//   ram_we/addr/di    RAM write port (registered, one cycle per data byte)
//   cpu_hold, busy    high while a frame is active (state != IDLE)
//   done              one-cycle pulse after a frame with a good checksum
//   error             sticky: bad checksum or inter-byte timeout; cleared
//                     by reset or by the next accepted SYNC
//   dbg_state         current parser state, for observation only
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int         ADDR_BITS      = 16,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_di,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [2:0]           dbg_state
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  state_e state_q, state_d;

  logic [7:0]           addr_hi_q, addr_hi_d;
  logic [7:0]           len_hi_q, len_hi_d;
  logic [15:0]          cnt_q, cnt_d;       // data bytes still to come
  logic [ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]           xor_q, xor_d;

  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [7:0]           wdi_q, wdi_d;
  logic                 hold_q, hold_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic                 tmo_expired;
  logic [15:0]          len_w;

  ram_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .kick    (rx_valid),
    .en      (state_q != ST_IDLE),
    .expired (tmo_expired)
  );

  assign len_w = {len_hi_q, rx_data};

  always_comb begin
    state_d    = state_q;
    addr_hi_d  = addr_hi_q;
    len_hi_d   = len_hi_q;
    cnt_d      = cnt_q;
    cur_addr_d = cur_addr_q;
    xor_d      = xor_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;   // address/data hold their last write value
    wdi_d      = wdi_q;
    done_d     = 1'b0;
    error_d    = error_q;

    if (tmo_expired) begin
      // Abandon the frame; whatever was already written stays in RAM.
      state_d = ST_IDLE;
      error_d = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = ST_ADDR_H;
            error_d = 1'b0;
            xor_d   = 8'h00;
          end
        end
        ST_ADDR_H: begin
          addr_hi_d = rx_data;
          xor_d     = xor_q ^ rx_data;
          state_d   = ST_ADDR_L;
        end
        ST_ADDR_L: begin
          cur_addr_d = ADDR_BITS'({addr_hi_q, rx_data});
          xor_d      = xor_q ^ rx_data;
          state_d    = ST_LEN_H;
        end
        ST_LEN_H: begin
          len_hi_d = rx_data;
          xor_d    = xor_q ^ rx_data;
          state_d  = ST_LEN_L;
        end
        ST_LEN_L: begin
          cnt_d   = len_w;
          xor_d   = xor_q ^ rx_data;
          state_d = (len_w == 16'd0) ? ST_CHK : ST_DATA;
        end
        ST_DATA: begin
          // A byte equal to SYNC_BYTE lands here as plain payload.
          we_d       = 1'b1;
          waddr_d    = cur_addr_q;
          wdi_d      = rx_data;
          cur_addr_d = cur_addr_q + ADDR_ONE;   // wraps modulo 2^ADDR_BITS
          cnt_d      = cnt_q - 16'd1;
          xor_d      = xor_q ^ rx_data;
          if (cnt_q == 16'd1) begin
            state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (rx_data == xor_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Registered from the next state so hold drops in the same cycle that
    // done/error rise.
    hold_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_hi_q  <= 8'h00;
      len_hi_q   <= 8'h00;
      cnt_q      <= 16'h0000;
      cur_addr_q <= '0;
      xor_q      <= 8'h00;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdi_q      <= 8'h00;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_hi_q  <= addr_hi_d;
      len_hi_q   <= len_hi_d;
      cnt_q      <= cnt_d;
      cur_addr_q <= cur_addr_d;
      xor_q      <= xor_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdi_q      <= wdi_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign ram_we    = we_q;
  assign ram_addr  = waddr_q;
  assign ram_di    = wdi_q;
  assign cpu_hold  = hold_q;
  assign busy      = hold_q;
  assign done      = done_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader
//   Directed bench for ram_loader: byte-level vector table for complete
//   frames, plus hand-written sequences for timeout and mid-frame reset.
module tb_ram_loader;
  import ram_loader_pkg::*;

  localparam int TMO = 100;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_di;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  int checks;
  int failures;

  ram_loader #(
    .ADDR_BITS      (16),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_di    (ram_di),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- write scoreboard ----------------
  logic [23:0] exp_q[$];

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%h@%h expected=none", ram_di, ram_addr);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({ram_addr, ram_di} !== e) begin
          failures++;
          $display("FAIL write actual=%h@%h expected=%h@%h", ram_di, ram_addr, e[7:0], e[23:8]);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  b;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  di;
    logic        dn;
    logic        er;
    logic        bz;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [7:0] b, input logic we, input logic [15:0] a,
                              input logic [7:0] d, input logic dn, input logic er, input logic bz);
    vec_t v;
    v.b = b; v.we = we; v.addr = a; v.di = d; v.dn = dn; v.er = er; v.bz = bz;
    vq.push_back(v);
    if (we) exp_q.push_back({a, d});
  endfunction

  // Non-data byte: no write, given done/error/busy.
  function automatic void addc(input logic [7:0] b, input logic dn, input logic er, input logic bz);
    add(b, 1'b0, 16'h0000, 8'h00, dn, er, bz);
  endfunction

  // Data byte: write at address, frame still busy.
  function automatic void addw(input logic [7:0] b, input logic [15:0] a, input logic er);
    add(b, 1'b1, a, b, 1'b0, er, 1'b1);
  endfunction

  // Drive the queued bytes on consecutive clocks; outputs for byte i are
  // checked on the falling edge after the rising edge that sampled it.
  task automatic run_vecs(input string tag);
    int n;
    n = vq.size();
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = vq[0].b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s_v%0d_we", tag, i), 32'(ram_we), 32'(vq[i].we));
      if (vq[i].we) begin
        check($sformatf("%s_v%0d_addr", tag, i), 32'(ram_addr), 32'(vq[i].addr));
        check($sformatf("%s_v%0d_di", tag, i), 32'(ram_di), 32'(vq[i].di));
      end
      check($sformatf("%s_v%0d_done", tag, i), 32'(done), 32'(vq[i].dn));
      check($sformatf("%s_v%0d_error", tag, i), 32'(error), 32'(vq[i].er));
      check($sformatf("%s_v%0d_busy", tag, i), 32'(busy), 32'(vq[i].bz));
      check($sformatf("%s_v%0d_hold", tag, i), 32'(cpu_hold), 32'(vq[i].bz));
      if (i + 1 < n) begin
        rx_data = vq[i+1].b;
      end else begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
      end
    end
    vq.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(ram_we),    32'd0);
    check({tag, "_addr"},  32'(ram_addr),  32'd0);
    check({tag, "_di"},    32'(ram_di),    32'd0);
    check({tag, "_hold"},  32'(cpu_hold),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_error"}, 32'(error),     32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- test ----------------
  initial begin
    int k;
    int seen_done;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Noise before any SYNC is ignored.
    addc(8'h00, 0, 0, 0);
    addc(8'hFF, 0, 0, 0);
    // Good frame: AA@1234 BB@1235 CC@1236, CHK=F8.
    addc(8'hA5, 0, 0, 1);
    addc(8'h12, 0, 0, 1); addc(8'h34, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h03, 0, 0, 1);
    addw(8'hAA, 16'h1234, 0); addw(8'hBB, 16'h1235, 0); addw(8'hCC, 16'h1236, 0);
    addc(8'hF8, 1, 0, 0);
    // Address wrap: 11@FFFF 22@0000, CHK=31.
    addc(8'hA5, 0, 0, 1);
    addc(8'hFF, 0, 0, 1); addc(8'hFF, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h02, 0, 0, 1);
    addw(8'h11, 16'hFFFF, 0); addw(8'h22, 16'h0000, 0);
    addc(8'h31, 1, 0, 0);
    // Bad checksum: writes still happen, error sets.
    addc(8'hA5, 0, 0, 1);
    addc(8'h12, 0, 0, 1); addc(8'h34, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h03, 0, 0, 1);
    addw(8'hAA, 16'h1234, 0); addw(8'hBB, 16'h1235, 0); addw(8'hCC, 16'h1236, 0);
    addc(8'hF9, 0, 1, 0);
    // Idle noise: error stays sticky.
    addc(8'h00, 0, 1, 0);
    addc(8'hFF, 0, 1, 0);
    // LEN=0 frame: SYNC clears error, no writes, CHK=10.
    addc(8'hA5, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h10, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h00, 0, 0, 1);
    addc(8'h10, 1, 0, 0);
    // SYNC bytes as payload: A5@0020 A5@0021, CHK=22.
    addc(8'hA5, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h20, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h02, 0, 0, 1);
    addw(8'hA5, 16'h0020, 0); addw(8'hA5, 16'h0021, 0);
    addc(8'h22, 1, 0, 0);
    run_vecs("frames");

    // Timeout: 2 of 5 data bytes, then silence.
    addc(8'hA5, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h40, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h05, 0, 0, 1);
    addw(8'h01, 16'h0040, 0); addw(8'h02, 16'h0041, 0);
    run_vecs("tmo");
    // Now on the falling edge after the last byte's edge; error must show
    // on the TMO-th following edge, not before.
    k = 0;
    seen_done = 0;
    for (int c = 1; c <= TMO + 50; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
      if (error === 1'b1) begin
        k = c;
        break;
      end
    end
    check("tmo_error_delay", 32'(k), 32'(TMO));
    check("tmo_no_done", 32'(seen_done), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_hold", 32'(cpu_hold), 32'd0);
    check("tmo_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (5) @(negedge clk);
    check("tmo_error_sticky", 32'(error), 32'd1);
    // Fresh frame after timeout: 77@0050, CHK=26.
    addc(8'hA5, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h50, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h01, 0, 0, 1);
    addw(8'h77, 16'h0050, 0);
    addc(8'h26, 1, 0, 0);
    run_vecs("post_tmo");

    // Reset in the middle of DATA.
    addc(8'hA5, 0, 0, 1);
    addc(8'h01, 0, 0, 1); addc(8'h00, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h04, 0, 0, 1);
    addw(8'h33, 16'h0100, 0); addw(8'h44, 16'h0101, 0);
    run_vecs("pre_rst");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_rst");
    rst = 1'b0;
    // Following frame parsed from SYNC: 55@0200, CHK=56.
    addc(8'hA5, 0, 0, 1);
    addc(8'h02, 0, 0, 1); addc(8'h00, 0, 0, 1);
    addc(8'h00, 0, 0, 1); addc(8'h01, 0, 0, 1);
    addw(8'h55, 16'h0200, 0);
    addc(8'h56, 1, 0, 0);
    run_vecs("post_rst");

    repeat (3) @(negedge clk);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(dbg_state), 32'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
